instr_rom_arbiter: RTL and testbench

Two-requester arbiter and response router for the shared single-port instruction ROM. The ROM takes a 14-bit byte address and returns a 32-bit word, registered, one cycle later.
- Requester F is the multicycle core's instruction fetch.
- Requester L is the load unit reading constant data from ROM space.
- Requests use valid/ready handshakes; arbitration is round-robin; at most one grant per cycle.
- Each response is routed back to its owner with a misalignment error flag. A fetch flush drops a stale fetch response after a jump or branch redirect.

---
 rtl/instr_rom_arbiter.sv | 66 ++++++
 tb/tb_instr_rom_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/instr_rom_arbiter.sv
// instr_rom_arbiter: round-robin arbiter routing fetch/load requests to a shared single-port ROM with 1-cycle responses
module instr_rom_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter bit RR_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  input  logic              f_flush,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic              f_rsp_err,
  input  logic              l_req_valid,
  input  logic [ADDR_W-1:0] l_req_addr,
  output logic              l_req_ready,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] l_rsp_data,
  output logic              l_rsp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);
  logic last_q, last_d;
  logic pend_v_q, pend_v_d;
  logic pend_owner_q, pend_owner_d;
  logic pend_err_q, pend_err_d;
  logic gnt_f, gnt_l, f_own, l_own, f_live;
  always_comb begin
    gnt_f        = f_req_valid && (!l_req_valid || last_q);
    gnt_l        = l_req_valid && (!f_req_valid || !last_q);
    f_req_ready  = gnt_f && !rst;
    l_req_ready  = gnt_l && !rst;
    rom_addr     = gnt_l ? l_req_addr : f_req_addr;
    last_d       = (gnt_f || gnt_l) ? gnt_l : last_q;
    pend_v_d     = gnt_f || gnt_l;
    pend_owner_d = gnt_l;
    pend_err_d   = pend_v_d && (rom_addr[1:0] != 2'b00);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= RR_INIT;
      pend_v_q     <= 1'b0;
      pend_owner_q <= 1'b0;
      pend_err_q   <= 1'b0;
    end else begin
      last_q       <= last_d;
      pend_v_q     <= pend_v_d;
      pend_owner_q <= pend_owner_d;
      pend_err_q   <= pend_err_d;
    end
  end
  // A flush only kills a fetch response; a pending load response passes untouched.
  always_comb begin
    f_own       = pend_v_q && !pend_owner_q;
    l_own       = pend_v_q && pend_owner_q;
    f_live      = f_own && !f_flush;
    f_rsp_valid = f_live;
    f_rsp_err   = f_live && pend_err_q;
    f_rsp_data  = (f_live && !pend_err_q) ? rom_data : '0;
    l_rsp_valid = l_own;
    l_rsp_err   = l_own && pend_err_q;
    l_rsp_data  = (l_own && !pend_err_q) ? rom_data : '0;
  end
endmodule

// File: tb/tb_instr_rom_arbiter.sv
// tb_instr_rom_arbiter: directed vectors against a registered ROM model with hand-computed expectations
module tb_instr_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_valid, f_req_ready, f_flush, f_rsp_valid, f_rsp_err;
  logic [13:0] f_req_addr, l_req_addr, rom_addr;
  logic [31:0] f_rsp_data, l_rsp_data, rom_data;
  logic        l_req_valid, l_req_ready, l_rsp_valid, l_rsp_err;
  int total = 0;
  int bad = 0;
  instr_rom_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .l_req_valid(l_req_valid), .l_req_addr(l_req_addr), .l_req_ready(l_req_ready),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data), .l_rsp_err(l_rsp_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(input logic [11:0] idx);
    case (idx)
      12'd0:   return 32'h00200193;
      12'd2:   return 32'h0100026f;
      12'd6:   return 32'h00000117;
      12'd11:  return 32'h00108093;
      12'd17:  return 32'h00300e93;
      12'd18:  return 32'h00300193;
      12'd19:  return 32'h01d09463;
      default: return {20'ha5a5a, idx};
    endcase
  endfunction
  always @(posedge clk) rom_data <= rom_word(rom_addr[13:2]);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic fv, input logic [13:0] fa, input logic lv, input logic [13:0] la, input logic fl);
    @(posedge clk);
    #1;
    f_req_valid = fv; f_req_addr = fa; l_req_valid = lv; l_req_addr = la; f_flush = fl;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    f_req_valid = 1'b1; f_req_addr = '0; l_req_valid = 1'b1; l_req_addr = '0; f_flush = 1'b0;
    #12;
    chk("rst_frdy", f_req_ready, 0);
    chk("rst_lrdy", l_req_ready, 0);
    chk("rst_fv", f_rsp_valid, 0);
    chk("rst_lv", l_rsp_valid, 0);
    f_req_valid = 1'b0; l_req_valid = 1'b0;
    #3 rst = 1'b0;
    drive(1, 14'h0000, 0, 0, 0);
    chk("f0_rdy", f_req_ready, 1);
    chk("f0_lrdy", l_req_ready, 0);
    chk("f0_addr", rom_addr, 32'h0);
    drive(0, 0, 0, 0, 0);
    chk("f0_rv", f_rsp_valid, 1);
    chk("f0_rd", f_rsp_data, 32'h00200193);
    chk("f0_re", f_rsp_err, 0);
    chk("f0_lv", l_rsp_valid, 0);
    drive(0, 0, 1, 14'h0022, 0);
    chk("mis_rdy", l_req_ready, 1);
    chk("mis_addr", rom_addr, 32'h22);
    drive(0, 0, 0, 0, 0);
    chk("mis_lv", l_rsp_valid, 1);
    chk("mis_le", l_rsp_err, 1);
    chk("mis_ld", l_rsp_data, 0);
    chk("mis_fv", f_rsp_valid, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 14'h0008, 1, 14'h0018, 0);
      else drive(0, 0, 0, 0, 0);
      if (i < 4) begin
        chk("rr_frdy", f_req_ready, (i % 2) == 0);
        chk("rr_lrdy", l_req_ready, (i % 2) == 1);
        chk("rr_addr", rom_addr, (i % 2) ? 32'h18 : 32'h8);
      end
      if (i > 0) begin
        chk("rr_fv", f_rsp_valid, (i % 2) == 1);
        chk("rr_lv", l_rsp_valid, (i % 2) == 0);
        chk("rr_fd", f_rsp_data, (i % 2) ? 32'h0100026f : 32'h0);
        chk("rr_ld", l_rsp_data, (i % 2) ? 32'h0 : 32'h00000117);
      end
    end
    drive(0, 0, 1, 14'h0018, 0);
    drive(0, 0, 0, 0, 1);
    chk("lfl_lv", l_rsp_valid, 1);
    chk("lfl_ld", l_rsp_data, 32'h00000117);
    drive(1, 14'h0014, 0, 0, 0);
    chk("fl_rdy0", f_req_ready, 1);
    drive(1, 14'h002c, 0, 0, 1);
    chk("fl_fv", f_rsp_valid, 0);
    chk("fl_fd", f_rsp_data, 0);
    chk("fl_rdy1", f_req_ready, 1);
    drive(0, 0, 0, 0, 0);
    chk("fl_fv2", f_rsp_valid, 1);
    chk("fl_fd2", f_rsp_data, 32'h00108093);
    drive(1, 14'h0044, 0, 0, 0);
    chk("b2b_rdy0", f_req_ready, 1);
    drive(1, 14'h0048, 0, 0, 0);
    chk("b2b_rdy1", f_req_ready, 1);
    chk("b2b_d0", f_rsp_data, 32'h00300e93);
    chk("b2b_v0", f_rsp_valid, 1);
    drive(1, 14'h004c, 0, 0, 0);
    chk("b2b_d1", f_rsp_data, 32'h00300193);
    chk("b2b_v1", f_rsp_valid, 1);
    drive(0, 0, 0, 0, 0);
    chk("b2b_d2", f_rsp_data, 32'h01d09463);
    chk("b2b_v2", f_rsp_valid, 1);
    drive(1, 14'h0000, 0, 0, 0);
    chk("ar_rdy", f_req_ready, 1);
    @(posedge clk);
    #1;
    f_req_valid = 1'b0;
    #1;
    chk("ar_pre", f_rsp_valid, 1);
    #2 rst = 1'b1;
    f_req_valid = 1'b1;
    #1;
    chk("ar_fv", f_rsp_valid, 0);
    chk("ar_fd", f_rsp_data, 0);
    chk("ar_frdy", f_req_ready, 0);
    f_req_valid = 1'b0;
    #1 rst = 1'b0;
    drive(1, 14'h0008, 1, 14'h0018, 0);
    chk("ar_cf", f_req_ready, 1);
    chk("ar_cl", l_req_ready, 0);
    drive(0, 0, 0, 0, 0);
    chk("ar_rsp", f_rsp_data, 32'h0100026f);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
